seg_scan_scheduler: RTL

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

---
 rtl/seg_scan_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexed 8-digit display scanner: per-slot blank/drive phases,
// leading-zero suppression and frame-aligned (tear-free) data commits.
module seg_scan_scheduler #(
    parameter int DIV   = 100000,
    parameter int GUARD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en,
    input  logic        lzs,
    output logic [3:0]  hex_out,
    output logic [7:0]  anode_n,
    output logic        dp_n,
    output logic [2:0]  digit_sel,
    output logic        busy,
    output logic        load_ack,
    output logic        frame_done
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   stage_data, act_data;
    logic [7:0]    stage_dp, act_dp;
    logic          pending, ack_q, frame_q;

    logic slot_end, commit_pos, do_commit;
    assign slot_end   = (cnt == CW'(DIV - 1));
    assign commit_pos = slot_end && (idx == 3'd7);
    assign do_commit  = commit_pos && (pending || load);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            stage_data <= '0;
            stage_dp   <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            pending    <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx + 3'd1;
            if (load) begin
                stage_data <= data;
                stage_dp   <= dp_in;
            end
            // A load landing in the commit cycle bypasses staging so it is not lost for a frame.
            if (do_commit) begin
                act_data <= load ? data  : stage_data;
                act_dp   <= load ? dp_in : stage_dp;
                pending  <= 1'b0;
            end else if (load) begin
                pending  <= 1'b1;
            end
            ack_q   <= do_commit;
            frame_q <= commit_pos;
        end
    end

    // upper_zero[k]: active nibbles k..7 are all zero
    logic [7:0] upper_zero;
    always_comb begin
        upper_zero    = '0;
        upper_zero[7] = (act_data[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--)
            upper_zero[k] = upper_zero[k+1] && (act_data[4*k +: 4] == 4'h0);
    end

    logic visible, drive;
    assign visible = en[idx] && !(lzs && (idx != 3'd0) && upper_zero[idx]);
    assign drive   = !reset && (cnt >= CW'(GUARD)) && visible;

    assign hex_out    = act_data[{idx, 2'b00} +: 4];
    assign anode_n    = drive ? ~(8'd1 << idx) : 8'hFF;
    assign dp_n       = drive ? ~act_dp[idx] : 1'b1;
    assign digit_sel  = idx;
    assign busy       = pending;
    assign load_ack   = ack_q;
    assign frame_done = frame_q;
endmodule
